// File: rtl/adder_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned NIB_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sum_inc4bit.sv
// Raw 4-bit adder: S = A + B, with the carry out of bit 3 on C.
module sum_inc4bit
    import adder_pkg::*;
(
    input  logic [NIB_W-1:0] A,
    input  logic [NIB_W-1:0] B,
    output logic [NIB_W-1:0] S,
    output logic             C
);

    assign {C, S} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one nibble per cycle through a single 4-bit adder,
// with a valid/ready handshake on both the operand and the result side.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    localparam int unsigned NNIB = WIDTH / NIB_W;
    localparam int unsigned IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NNIB - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              carry_q, carry_d;
    logic              c_q, c_d;
    logic [IDXW-1:0]   idx_q, idx_d;

    logic [NIB_W-1:0]  nib_a, nib_b;
    logic [NIB_W-1:0]  raw_sum;
    logic              raw_carry;
    logic [NIB_W-1:0]  nib_res;
    logic              nib_cout;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NNIB; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_a = a_q[i*NIB_W +: NIB_W];
                nib_b = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    sum_inc4bit u_sum (
        .A (nib_a),
        .B (nib_b),
        .S (raw_sum),
        .C (raw_carry)
    );

    // Carry-in is applied as a separate increment on the raw nibble sum;
    // it can only ripple out when the raw sum is all ones.
    always_comb begin
        nib_res  = carry_q ? (raw_sum + 4'd1) : raw_sum;
        nib_cout = raw_carry | (carry_q & (raw_sum == 4'hF));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_d     = c_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = CI;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NNIB; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        s_d[i*NIB_W +: NIB_W] = nib_res;
                    end
                end
                carry_d = nib_cout;
                if (idx_q == LAST_IDX) begin
                    c_d     = nib_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
        end
    end

    // Operands have no reset: they only ever change on an accept edge.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign C         = c_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder with directed, hand-computed vectors.
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CI;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         C;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .CI        (CI),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .C         (C)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int unsigned  acc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    endfunction

    // Monitor: latency on each rising out_valid, data on each handshake.
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
                else check({sb[0].name, "_latency"}, cyc - sb[0].acc, LAT);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, "_S"}, 32'(S), 32'(e.s));
                check({e.name, "_C"}, 32'(C), 32'(e.c));
            end
        end
        ov_prev = out_valid;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] s, input logic c, input string name);
        int unsigned k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check({name, "_in_ready_timeout"}, 32'd0, 32'd1);
        A = a; B = b; CI = ci; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        sb.push_back('{s, c, cyc, name});
    endtask

    task automatic drain();
        int unsigned k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; CI = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_S",         32'(S),         32'd0);
        check("reset_C",         32'(C),         32'd0);
        rst = 1'b0;

        issue(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, "v_1p2");
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "v_ffff_p1");
        issue(16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, "v_f_ci");
        issue(16'hABCD, 16'h6789, 1'b1, 16'h1357, 1'b1, "v_abcd");
        issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "v_msb_carry");
        issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "v_all_ones");
        issue(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, "v_zero");
        drain();

        // Back-pressure: result held while out_ready is low, new offers ignored.
        out_ready = 1'b0;
        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "v_stall");
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("stall_out_valid_rise", 32'(out_valid), 32'd1);
        A = 16'hFFFF; B = 16'hFFFF; CI = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_S",         32'(S),         32'h5555);
            check("stall_C",         32'(C),         32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        repeat (2) @(negedge clk);
        check("post_stall_in_ready",  32'(in_ready),  32'd1);
        check("post_stall_out_valid", 32'(out_valid), 32'd0);

        // Reset after two nibbles of an operation discards it.
        issue(16'h5555, 16'h1111, 1'b0, 16'h6666, 1'b0, "v_aborted");
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_reset_in_ready",  32'(in_ready),  32'd1);
        check("midrun_reset_out_valid", 32'(out_valid), 32'd0);
        check("midrun_reset_S",         32'(S),         32'd0);
        check("midrun_reset_C",         32'(C),         32'd0);
        rst = 1'b0;

        issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, "v_after_reset");
        drain();
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
